exec_unit_seq: RTL and testbench
================================

Name: exec_unit_seq

Overview:
Multi-cycle successor to the single-cycle operational block.
- Holds a parametrised register file and an extended ALU: logic ops, shifts, and an optional iterative multiplier.
- Status flags are registered.
- Ops arrive from the control block through a valid/ready request port. Each op completes with a one-cycle response pulse.
- Sits between the controller and data memory. It supplies memory write data and consumes memory read data.

Parameters:
WIDTH, 16, datapath and register width (at least 4; must be a power of 2).
REGBITS, 4, register address bits; the file holds 2**REGBITS registers.
IMMW, 8, immediate width; sign-extended to WIDTH.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  op request valid
req_ready  out  1  unit can accept an op
req_op  in  4  opcode (op_e)
req_dst  in  REGBITS  destination register
req_p  in  REGBITS  operand P register
req_q  in  REGBITS  operand Q register
req_imm  in  IMMW  immediate for LOADI
mem_rdata  in  WIDTH  data-memory read data for LOADM
rsp_valid  out  1  one-cycle completion pulse
rsp_result  out  WIDTH  value written back (valid with rsp_valid)
w_data  out  WIDTH  latched operand P, for memory writes
rp_zero  out  1  latched operand P == 0, for branch decisions
flag_z, flag_n, flag_c  out  1 each  registered status flags
err  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (async, rst_n=0) forces:
  - state IDLE; all registers of the file = 0;
  - rsp_valid=0, rsp_result=0, w_data=0, rp_zero=1;
  - all flags=0, err=0; req_ready=0 while rst_n=0.
- Opcodes:
  - BYPASS=0 (P), ADD=1 (P+Q), SUB=2 (P+~Q+1), LOADI=3 (sext imm), LOADM=4 (mem_rdata);
  - AND=5, OR=6, XOR=7;
  - SHL=8 and SHR=9 (logical; shift amount = Q[$clog2(WIDTH)-1:0]);
  - MUL=10 (low WIDTH bits of P*Q, unsigned); 11-15 illegal.
- FSM states: IDLE, EXEC, MUL, WB.
  - IDLE: req_ready=1. Handshake = req_valid & req_ready at a rising edge. On handshake:
    - latch op, dst, imm, and rf[req_p], rf[req_q];
    - w_data <= rf[req_p]; rp_zero <= (rf[req_p]==0);
    - go to MUL if op==MUL (feature enabled), else EXEC.
  - EXEC: one cycle. Compute the result and latch it (LOADM samples mem_rdata in this cycle). Go to WB.
  - MUL: shift-add, one bit of Q per cycle, exactly WIDTH cycles. Then go to WB.
  - WB: one cycle.
    - rsp_valid=1 and rsp_result=latched result.
    - At the closing edge, rf[dst] <= result and the flags update. Then go to IDLE.
- Latency: for an op accepted at edge E0, rsp_valid is high between E1 and E2, and the register is written at E2. Next accept is possible at E3, giving 3 cycles per op. MUL takes WIDTH+2 cycles.
- Flags:
  - flag_z = (result==0) and flag_n = result[WIDTH-1]; both updated for every legal op.
  - flag_c updated only for:
    - ADD: carry-out;
    - SUB: carry-out (1 = no borrow);
    - SHL: last bit shifted out;
    - a shift amount of 0 gives c=0.
  - flag_c holds for all other ops.
- Illegal op:
  - takes the EXEC→WB path with rsp_valid pulsing and rsp_result=0;
  - no register write and no flag update;
  - err <= 1 and stays set until reset.
- Hazards:
  - dst==p or dst==q: operands were latched at accept, so the new value is written correctly.
  - Back-to-back ops see the prior write, because WB completes before the next accept.
- Reset asserted mid-op aborts it at once: no write and no response pulse.
- req_* is ignored outside IDLE.

Optional Feature:
- Macro EXEC_UNIT_MUL_EN.
- Defined: MUL state and shift-add multiplier present; MUL behaves as above.
- Undefined: MUL state and multiplier hardware absent; opcode 10 is treated as illegal.

Decomposition:
- Package exec_unit_pkg holds:
  - op_e (4-bit opcode enum);
  - state_e (IDLE/EXEC/MUL/WB);
  - the function for the shift-amount width, $clog2(WIDTH).
- One sub-module, seq_multiplier (start/busy/done, WIDTH-cycle shift-add), instantiated only under EXEC_UNIT_MUL_EN.
- The register file remains inline.

Test Plan:
- Reset then LOADI r1, imm=0xFF → rsp_result=0xFFFF, flag_n=1, flag_z=0, and rsp_valid exactly 2 edges after accept.
- LOADI r2=5, LOADI r3=5, SUB r4=r2-r3 → result 0, flag_z=1, flag_c=1; then SUB r4=r3-r1 (5-(-1)) → 6, flag_c=0.
- Setup: r1=0x8001, r2=1, then SHL r5=r1<<r2 → 0x0002, flag_c=1. With r2=0 → 0x8001, flag_c=0. SHR by 15 → 0x0001.
- MUL r6=r3*r3 (5*5):
  - macro on: 25, with rsp_valid WIDTH+1 edges after accept;
  - macro off: err=1, r6 unchanged, rsp_result=0.
- Hold req_valid high continuously → req_ready drops after accept; exactly one op is taken per 3 cycles (MUL: WIDTH+2); no op is lost or duplicated.
- Deassert rst_n during EXEC of ADD r7 → r7=0, no rsp_valid pulse, all outputs return to their reset values immediately (asynchronously).

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Shared types for the multi-cycle execution unit: opcode and FSM state
// encodings plus the shift-amount width helper.
package exec_unit_pkg;

    typedef enum logic [3:0] {
        OP_BYPASS = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_LOADI  = 4'd3,
        OP_LOADM  = 4'd4,
        OP_AND    = 4'd5,
        OP_OR     = 4'd6,
        OP_XOR    = 4'd7,
        OP_SHL    = 4'd8,
        OP_SHR    = 4'd9,
        OP_MUL    = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic int shamt_bits(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/exec_unit_seq_mul.sv
// Iterative shift-add multiplier: consumes one bit of b per cycle for WIDTH
// cycles and returns the low WIDTH bits of a*b alongside a one-cycle done.
module seq_multiplier
    import exec_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = shamt_bits(WIDTH) + 1;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    assign acc_d = acc_q + (b_q[0] ? a_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // The final partial product is forwarded combinationally so the caller
    // can latch it on the same edge that ends the last iteration.
    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CW'(1));
    assign product_o = acc_d;

endmodule

// File: rtl/exec_unit_seq.sv
// Multi-cycle execution unit: register file, ALU and FSM behind a valid/ready
// op port. Optional iterative MUL is enabled by defining EXEC_UNIT_MUL_EN.
module exec_unit_seq
    import exec_unit_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int IMMW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [REGBITS-1:0] req_dst,
    input  logic [REGBITS-1:0] req_p,
    input  logic [REGBITS-1:0] req_q,
    input  logic [IMMW-1:0]    req_imm,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [WIDTH-1:0]   w_data,
    output logic               rp_zero,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               err
);

    localparam int NREG = 2 ** REGBITS;
    localparam int SHW  = shamt_bits(WIDTH);

    state_e             state_q;
    logic [3:0]         op_q;
    logic [REGBITS-1:0] dst_q;
    logic [IMMW-1:0]    imm_q;
    logic [WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   w_data_q;
    logic               rp_zero_q;
    logic               rsp_valid_q;
    logic               legal_q;
    logic               c_upd_q;
    logic               c_val_q;
    logic               flag_z_q;
    logic               flag_n_q;
    logic               flag_c_q;
    logic               err_q;
    logic [WIDTH-1:0]   rf_q [NREG];

    logic [WIDTH-1:0]   rd_p;
    logic [WIDTH-1:0]   rd_q;
    logic               accept;
    logic               is_mul;
    logic               rf_we;

    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign rd_p      = rf_q[req_p];
    assign rd_q      = rf_q[req_q];
    assign rf_we     = (state_q == ST_WB) && legal_q;

`ifdef EXEC_UNIT_MUL_EN
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign is_mul = (req_op == OP_MUL);

    seq_multiplier #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && is_mul),
        .a_i      (rd_p),
        .b_i      (rd_q),
        .busy_o   (mul_busy),
        .done_o   (mul_done),
        .product_o(mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;
    logic             alu_cupd;
    logic             alu_c;

    assign shamt = q_q[SHW-1:0];

    always_comb begin
        wide      = '0;
        alu_res   = '0;
        alu_legal = 1'b1;
        alu_cupd  = 1'b0;
        alu_c     = 1'b0;
        case (op_q)
            OP_BYPASS: alu_res = p_q;
            OP_ADD: begin
                wide     = {1'b0, p_q} + {1'b0, q_q};
                alu_res  = wide[WIDTH-1:0];
                alu_c    = wide[WIDTH];
                alu_cupd = 1'b1;
            end
            OP_SUB: begin
                wide     = {1'b0, p_q} + {1'b0, ~q_q} + (WIDTH+1)'(1);
                alu_res  = wide[WIDTH-1:0];
                alu_c    = wide[WIDTH];
                alu_cupd = 1'b1;
            end
            OP_LOADI:  alu_res = WIDTH'($signed(imm_q));
            OP_LOADM:  alu_res = mem_rdata;
            OP_AND:    alu_res = p_q & q_q;
            OP_OR:     alu_res = p_q | q_q;
            OP_XOR:    alu_res = p_q ^ q_q;
            OP_SHL: begin
                // The extra top bit catches the last bit shifted out; zero for shamt 0.
                wide     = {1'b0, p_q} << shamt;
                alu_res  = wide[WIDTH-1:0];
                alu_c    = wide[WIDTH];
                alu_cupd = 1'b1;
            end
            OP_SHR:    alu_res = p_q >> shamt;
            default:   alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[dst_q] <= result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            dst_q       <= '0;
            imm_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            result_q    <= '0;
            w_data_q    <= '0;
            rp_zero_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            legal_q     <= 1'b0;
            c_upd_q     <= 1'b0;
            c_val_q     <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= req_op;
                        dst_q     <= req_dst;
                        imm_q     <= req_imm;
                        p_q       <= rd_p;
                        q_q       <= rd_q;
                        w_data_q  <= rd_p;
                        rp_zero_q <= (rd_p == '0);
                        state_q   <= is_mul ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= alu_res;
                    legal_q     <= alu_legal;
                    c_upd_q     <= alu_cupd;
                    c_val_q     <= alu_c;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_WB;
                end
`ifdef EXEC_UNIT_MUL_EN
                ST_MUL: begin
                    if (mul_done) begin
                        result_q    <= mul_product;
                        legal_q     <= 1'b1;
                        c_upd_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_WB;
                    end else if (!mul_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
`endif
                ST_WB: begin
                    if (legal_q) begin
                        flag_z_q <= (result_q == '0);
                        flag_n_q <= result_q[WIDTH-1];
                        if (c_upd_q) begin
                            flag_c_q <= c_val_q;
                        end
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign w_data     = w_data_q;
    assign rp_zero    = rp_zero_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign flag_c     = flag_c_q;
    assign err        = err_q;

endmodule

// File: tb/tb_exec_unit_seq.sv
// Self-checking bench for exec_unit_seq: directed scenarios plus random ops
// scored against an arithmetic reference model of the register file and flags.
module tb_exec_unit_seq;

    localparam int W    = 16;
    localparam int RB   = 4;
    localparam int IMMW = 8;
`ifdef EXEC_UNIT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [RB-1:0] req_dst, req_p, req_q;
    logic [IMMW-1:0] req_imm;
    logic [W-1:0]  mem_rdata;
    logic          rsp_valid;
    logic [W-1:0]  rsp_result;
    logic [W-1:0]  w_data;
    logic          rp_zero, flag_z, flag_n, flag_c, err;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] m_rf [16];
    logic m_z, m_n, m_c, m_err;

    always #5 clk = ~clk;

    exec_unit_seq #(.WIDTH(W), .REGBITS(RB), .IMMW(IMMW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_dst(req_dst), .req_p(req_p), .req_q(req_q), .req_imm(req_imm),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .w_data(w_data), .rp_zero(rp_zero),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .err(err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_z = 0; m_n = 0; m_c = 0; m_err = 0;
    endtask

    // Reference semantics from plain integer arithmetic; applies the op to the model.
    task automatic model_op(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] p,
                            input logic [3:0] q, input logic [7:0] imm, input logic [15:0] mem,
                            output logic [15:0] res);
        longint a, b, full, mask;
        int s;
        bit legal, cu, cv;
        a = longint'(m_rf[p]);
        b = longint'(m_rf[q]);
        s = int'(b % W);
        mask = (longint'(1) << W) - 1;
        full = 0; legal = 1; cu = 0; cv = 0;
        case (op)
            4'd0: full = a;
            4'd1: begin full = a + b; cu = 1; cv = (full > mask); end
            4'd2: begin full = a - b; cu = 1; cv = (a >= b); end
            4'd3: full = (imm >= 8'd128) ? longint'(imm) - 256 : longint'(imm);
            4'd4: full = longint'(mem);
            4'd5: full = a & b;
            4'd6: full = a | b;
            4'd7: full = a ^ b;
            4'd8: begin full = a << s; cu = 1; cv = (s != 0) && (((a >> (W - s)) & 1) == 1); end
            4'd9: full = a >> s;
            4'd10: if (MUL_EN) full = a * b; else legal = 0;
            default: legal = 0;
        endcase
        res = legal ? 16'(full & mask) : 16'h0;
        if (legal) begin
            m_rf[dst] = res;
            m_z = (res == 0);
            m_n = res[W-1];
            if (cu) m_c = cv;
        end else begin
            m_err = 1;
        end
    endtask

    // Called at a negedge; returns at the negedge after write-back with the unit idle.
    task automatic do_op(input logic [3:0] op, input logic [3:0] dst, input logic [3:0] p,
                         input logic [3:0] q, input logic [7:0] imm, input logic [15:0] mem,
                         output logic [15:0] got);
        logic [15:0] exp_res, exp_w;
        int lat, waitc, exp_lat;
        waitc = 0;
        while (!req_ready && waitc < 100) begin @(negedge clk); waitc++; end
        check_val("accept_ready", req_ready, 1);
        exp_w   = m_rf[p];
        exp_lat = (op == 4'd10 && MUL_EN) ? W + 1 : 2;
        model_op(op, dst, p, q, imm, mem, exp_res);
        req_valid = 1; req_op = op; req_dst = dst; req_p = p; req_q = q;
        req_imm = imm; mem_rdata = mem;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        lat = 1;
        check_val("w_data", w_data, exp_w);
        check_val("rp_zero", rp_zero, exp_w == 0);
        check_val("busy_not_ready", req_ready, 0);
        while (!rsp_valid && lat < 3 * W) begin @(negedge clk); lat++; end
        check_val("latency", lat, exp_lat);
        check_val("result", rsp_result, exp_res);
        got = rsp_result;
        @(negedge clk);
        check_val("pulse_end", rsp_valid, 0);
        check_val("flag_z", flag_z, m_z);
        check_val("flag_n", flag_n, m_n);
        check_val("flag_c", flag_c, m_c);
        check_val("err", err, m_err);
        $display("op=%0d dst=r%0d p=r%0d q=r%0d imm=%02h -> result=%04h lat=%0d zncE=%b%b%b%b",
                 op, dst, p, q, imm, got, lat, flag_z, flag_n, flag_c, err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, req_ready, 0);
        check_val({tag, "_rsp_valid"}, rsp_valid, 0);
        check_val({tag, "_rsp_result"}, rsp_result, 0);
        check_val({tag, "_w_data"}, w_data, 0);
        check_val({tag, "_rp_zero"}, rp_zero, 1);
        check_val({tag, "_flags"}, {flag_z, flag_n, flag_c}, 0);
        check_val({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] hq [$];
        int acc, rsps, last;

        rst_n = 0; req_valid = 0; req_op = 0; req_dst = 0; req_p = 0; req_q = 0;
        req_imm = 0; mem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1;
        @(negedge clk);
        check_val("ready_after_reset", req_ready, 1);

        do_op(4'd3, 4'd1, 4'd0, 4'd0, 8'hFF, 16'h0, got);
        check_val("loadi_ff", got, 16'hFFFF);
        check_val("loadi_ff_n", flag_n, 1);
        check_val("loadi_ff_z", flag_z, 0);

        do_op(4'd3, 4'd2, 4'd0, 4'd0, 8'd5, 16'h0, got);
        do_op(4'd3, 4'd3, 4'd0, 4'd0, 8'd5, 16'h0, got);
        do_op(4'd2, 4'd4, 4'd2, 4'd3, 8'd0, 16'h0, got);
        check_val("sub_eq", got, 16'h0000);
        check_val("sub_eq_zc", {flag_z, flag_c}, 2'b11);
        do_op(4'd2, 4'd4, 4'd3, 4'd1, 8'd0, 16'h0, got);
        check_val("sub_borrow", got, 16'h0006);
        check_val("sub_borrow_c", flag_c, 0);

        do_op(4'd4, 4'd1, 4'd0, 4'd0, 8'd0, 16'h8001, got);
        do_op(4'd3, 4'd2, 4'd0, 4'd0, 8'd1, 16'h0, got);
        do_op(4'd8, 4'd5, 4'd1, 4'd2, 8'd0, 16'h0, got);
        check_val("shl1", got, 16'h0002);
        check_val("shl1_c", flag_c, 1);
        do_op(4'd3, 4'd2, 4'd0, 4'd0, 8'd0, 16'h0, got);
        do_op(4'd8, 4'd5, 4'd1, 4'd2, 8'd0, 16'h0, got);
        check_val("shl0", got, 16'h8001);
        check_val("shl0_c", flag_c, 0);
        do_op(4'd3, 4'd2, 4'd0, 4'd0, 8'd15, 16'h0, got);
        do_op(4'd9, 4'd5, 4'd1, 4'd2, 8'd0, 16'h0, got);
        check_val("shr15", got, 16'h0001);

        do_op(4'd10, 4'd6, 4'd3, 4'd3, 8'd0, 16'h0, got);
        check_val("mul_5x5", got, MUL_EN ? 16'd25 : 16'd0);
        check_val("mul_err", err, MUL_EN ? 1'b0 : 1'b1);
        do_op(4'd0, 4'd8, 4'd6, 4'd0, 8'd0, 16'h0, got);
        check_val("r6_after_mul", got, MUL_EN ? 16'd25 : 16'd0);

        // Continuous request: r8 += r9 must be taken once every 3 cycles.
        do_op(4'd3, 4'd9, 4'd0, 4'd0, 8'd1, 16'h0, got);
        do_op(4'd3, 4'd8, 4'd0, 4'd0, 8'd0, 16'h0, got);
        req_valid = 1; req_op = 4'd1; req_dst = 4'd8; req_p = 4'd8; req_q = 4'd9;
        acc = 0; rsps = 0; last = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (rsp_valid) begin
                if (hq.size() == 0) check_val("hold_extra_rsp", 1, 0);
                else check_val("hold_result", rsp_result, hq.pop_front());
                rsps++;
            end
            if (req_ready) begin
                if (acc > 0) check_val("hold_gap", cyc - last, 3);
                model_op(4'd1, 4'd8, 4'd8, 4'd9, 8'd0, 16'h0, got);
                hq.push_back(got);
                last = cyc;
                acc++;
            end
            @(negedge clk);
        end
        req_valid = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid) begin
                if (hq.size() == 0) check_val("hold_extra_rsp", 1, 0);
                else check_val("hold_result", rsp_result, hq.pop_front());
                rsps++;
            end
            @(negedge clk);
        end
        check_val("hold_accepts", acc, 14);
        check_val("hold_rsps", rsps, 14);
        $display("hold test: %0d accepts, %0d responses", acc, rsps);

        for (int i = 0; i < 120; i++) begin
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom), got);
        end

        // Abort an ADD in its EXEC cycle with an asynchronous reset.
        do_op(4'd3, 4'd3, 4'd0, 4'd0, 8'd5, 16'h0, got);
        req_valid = 1; req_op = 4'd1; req_dst = 4'd7; req_p = 4'd3; req_q = 4'd3;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        check_reset_outputs("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("abort_no_pulse", rsp_valid, 0);
        end
        rst_n = 1;
        model_reset();
        @(negedge clk);
        do_op(4'd0, 4'd5, 4'd7, 4'd0, 8'd0, 16'h0, got);
        check_val("r7_after_abort", got, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
